// File: rtl/fir_root_pipe.sv
// fir_root_pipe: time-multiplexed FIR (one tap per cycle, runtime-loadable
// coefficients) followed by scale/saturate and a bit-per-cycle integer sqrt.
// Latency: TAPS+1+DW/2 cycles from accept to Out_valid (one more with
// FIR_ROOT_ROUND_EN, which rounds the root to nearest instead of flooring).
// Backpressure: accepts only in IDLE; result held in OUT until Out_ready.
// Ports:
//   Clk, Rst          clock, synchronous active-high reset
//   Data_i/In_valid/In_ready   sample input handshake
//   Coef_we/Coef_addr/Coef_data  coefficient write port (IDLE only)
//   FIRout/ROOTout/Out_valid/Out_ready  result output handshake
module fir_root_pipe #(
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int TAPS  = 7,
  parameter int SHIFT = 0
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [DW-1:0]            Data_i,
  input  logic                     In_valid,
  output logic                     In_ready,
  input  logic                     Coef_we,
  input  logic [$clog2(TAPS)-1:0]  Coef_addr,
  input  logic [CW-1:0]            Coef_data,
  output logic [DW-1:0]            FIRout,
  output logic [DW/2-1:0]          ROOTout,
  output logic                     Out_valid,
  input  logic                     Out_ready
);

  localparam int IW = $clog2(TAPS);
  localparam int AW = DW + CW + IW;   // wide enough that the sum never wraps
  localparam int HW = DW / 2;
  localparam int RW = HW + 2;         // sqrt partial remainder width
  localparam int BW = $clog2(HW);

  typedef enum logic [2:0] {
    S_IDLE, S_MAC, S_SAT, S_SQRT, S_RND, S_OUT
  } state_t;

  state_t r_state, w_next;

  logic [DW-1:0]    r_x [TAPS];
  logic [CW-1:0]    r_b [TAPS];
  logic [AW-1:0]    r_acc;
  logic [IW-1:0]    r_tap;
  logic [BW-1:0]    r_bit;
  logic [DW-1:0]    r_y;
  logic [DW-1:0]    r_rad;
  logic [RW-1:0]    r_rem;
  logic [HW-1:0]    r_root;
  logic [DW-1:0]    r_fir_q;
  logic [HW-1:0]    r_root_q;

  logic [DW+CW-1:0] w_prod;
  logic [AW-1:0]    w_y;
  logic             w_sat;
  logic [RW-1:0]    w_rem_sh;
  logic [RW-1:0]    w_trial;
  logic             w_ge;
  logic [RW-1:0]    w_rem_nxt;
  logic [HW-1:0]    w_root_nxt;

  assign w_prod = r_x[r_tap] * r_b[r_tap];
  assign w_y    = r_acc >> SHIFT;
  assign w_sat  = |w_y[AW-1:DW];

  // Restoring root step: bring down two radicand bits, try subtracting 4r+1.
  assign w_rem_sh   = {r_rem[RW-3:0], r_rad[DW-1:DW-2]};
  assign w_trial    = {r_root, 2'b01};
  assign w_ge       = (w_rem_sh >= w_trial);
  assign w_rem_nxt  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
  assign w_root_nxt = {r_root[HW-2:0], w_ge};

`ifdef FIR_ROOT_ROUND_EN
  // rem = v - r^2; rounding up is correct when rem > r. Clamp at all-ones.
  logic [HW-1:0] w_root_rnd;
  always_comb begin
    w_root_rnd = r_root;
    if ((r_rem > {2'b00, r_root}) && (r_root != '1)) begin
      w_root_rnd = r_root + 1'b1;
    end
  end
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (In_valid) w_next = S_MAC;
      S_MAC:  if (r_tap == IW'(TAPS - 1)) w_next = S_SAT;
      S_SAT:  w_next = S_SQRT;
      S_SQRT: begin
        if (r_bit == '0) begin
`ifdef FIR_ROOT_ROUND_EN
          w_next = S_RND;
`else
          w_next = S_OUT;
`endif
        end
      end
      S_RND:  w_next = S_OUT;
      S_OUT:  if (Out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < TAPS; i++) begin
        r_x[i] <= '0;
        r_b[i] <= '0;
      end
      r_acc    <= '0;
      r_tap    <= '0;
      r_bit    <= '0;
      r_y      <= '0;
      r_rad    <= '0;
      r_rem    <= '0;
      r_root   <= '0;
      r_fir_q  <= '0;
      r_root_q <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Coefficient lands at this edge, so a sample accepted in the
          // same cycle already sees it during MAC.
          if (Coef_we && (int'(Coef_addr) < TAPS)) begin
            r_b[Coef_addr] <= Coef_data;
          end
          if (In_valid) begin
            r_x[0] <= Data_i;
            for (int i = 1; i < TAPS; i++) begin
              r_x[i] <= r_x[i-1];
            end
            r_acc <= '0;
            r_tap <= '0;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + AW'(w_prod);
          r_tap <= r_tap + 1'b1;
        end
        S_SAT: begin
          r_y    <= w_sat ? '1 : w_y[DW-1:0];
          r_rad  <= w_sat ? '1 : w_y[DW-1:0];
          r_rem  <= '0;
          r_root <= '0;
          r_bit  <= BW'(HW - 1);
        end
        S_SQRT: begin
          r_rad  <= r_rad << 2;
          r_rem  <= w_rem_nxt;
          r_root <= w_root_nxt;
          r_bit  <= r_bit - 1'b1;
`ifndef FIR_ROOT_ROUND_EN
          if (r_bit == '0) begin
            r_fir_q  <= r_y;
            r_root_q <= w_root_nxt;
          end
`endif
        end
        S_RND: begin
`ifdef FIR_ROOT_ROUND_EN
          r_fir_q  <= r_y;
          r_root_q <= w_root_rnd;
`endif
        end
        default: ;
      endcase
    end
  end

  assign In_ready  = (r_state == S_IDLE);
  assign Out_valid = (r_state == S_OUT);
  assign FIRout    = r_fir_q;
  assign ROOTout   = r_root_q;

endmodule

// File: tb/tb_fir_root_pipe.sv
// Directed bench for fir_root_pipe: table-driven unity/impulse vectors plus
// hand-written saturation, backpressure, coefficient-timing and reset cases.
// A second instance with SHIFT=16 shares all inputs for the scaling check.
module tb_fir_root_pipe;

  localparam int DW = 8;
  localparam int CW = 8;
  localparam int TAPS = 7;
`ifdef FIR_ROOT_ROUND_EN
  localparam int LAT = 13;
`else
  localparam int LAT = 12;
`endif

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] Data_i = '0;
  logic       In_valid = 1'b0;
  logic       Coef_we = 1'b0;
  logic [2:0] Coef_addr = '0;
  logic [7:0] Coef_data = '0;
  logic       Out_ready = 1'b1;
  logic       In_ready, Out_valid, In_ready16, Out_valid16;
  logic [7:0] FIRout, FIRout16;
  logic [3:0] ROOTout, ROOTout16;

  always #5 Clk = ~Clk;

  fir_root_pipe #(.DW(DW), .CW(CW), .TAPS(TAPS), .SHIFT(0)) u_dut (
    .Clk(Clk), .Rst(Rst), .Data_i(Data_i), .In_valid(In_valid),
    .In_ready(In_ready), .Coef_we(Coef_we), .Coef_addr(Coef_addr),
    .Coef_data(Coef_data), .FIRout(FIRout), .ROOTout(ROOTout),
    .Out_valid(Out_valid), .Out_ready(Out_ready)
  );

  fir_root_pipe #(.DW(DW), .CW(CW), .TAPS(TAPS), .SHIFT(16)) u_dut16 (
    .Clk(Clk), .Rst(Rst), .Data_i(Data_i), .In_valid(In_valid),
    .In_ready(In_ready16), .Coef_we(Coef_we), .Coef_addr(Coef_addr),
    .Coef_data(Coef_data), .FIRout(FIRout16), .ROOTout(ROOTout16),
    .Out_valid(Out_valid16), .Out_ready(Out_ready)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Expected root given the hand-computed floor root.
  function automatic int rt(input int v, input int r);
    int q;
    q = r;
`ifdef FIR_ROOT_ROUND_EN
    if ((v - r * r) > r && r < 15) q = r + 1;
`endif
    return q;
  endfunction

  task automatic do_reset();
    Rst = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic wcoef(input int a, input int d);
    Coef_we = 1'b1;
    Coef_addr = 3'(a);
    Coef_data = 8'(d);
    @(negedge Clk);
    Coef_we = 1'b0;
  endtask

  // Present one sample in IDLE; return edges from accept to Out_valid.
  task automatic send(input int din, output int lat);
    In_valid = 1'b1;
    Data_i = 8'(din);
    @(negedge Clk);
    In_valid = 1'b0;
    lat = 0;
    while (!Out_valid && lat < 60) begin
      @(negedge Clk);
      lat++;
    end
  endtask

  task automatic send_check(input string nm, input int din, input int efir, input int eroot);
    int lat;
    send(din, lat);
    check({nm, ".lat"}, lat, LAT);
    check({nm, ".fir"}, FIRout, efir);
    check({nm, ".root"}, ROOTout, rt(efir, eroot));
    @(negedge Clk);
  endtask

  typedef struct {
    int din;
    int fir;
    int root;
  } vec_t;

  vec_t uni[6];
  vec_t imp[7];

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    uni[0] = '{16, 16, 4};
    uni[1] = '{100, 100, 10};
    uni[2] = '{13, 13, 3};
    uni[3] = '{12, 12, 3};
    uni[4] = '{255, 255, 15};
    uni[5] = '{0, 0, 0};
    imp[0] = '{1, 1, 1};
    imp[1] = '{0, 2, 1};
    imp[2] = '{0, 3, 1};
    imp[3] = '{0, 4, 2};
    imp[4] = '{0, 5, 2};
    imp[5] = '{0, 6, 2};
    imp[6] = '{0, 7, 2};

    do_reset();
    check("rst.in_ready", In_ready, 1);
    check("rst.out_valid", Out_valid, 0);
    check("rst.fir", FIRout, 0);
    check("rst.root", ROOTout, 0);

    // Unity tap: output equals newest sample.
    wcoef(0, 1);
    for (int i = 0; i < 6; i++) send_check($sformatf("uni%0d", i), uni[i].din, uni[i].fir, uni[i].root);

    // Impulse response with b[i] = i+1.
    do_reset();
    for (int i = 0; i < TAPS; i++) wcoef(i, i + 1);
    for (int i = 0; i < 7; i++) send_check($sformatf("imp%0d", i), imp[i].din, imp[i].fir, imp[i].root);

    // Saturation; SHIFT=16 copy sees 7*255*255 = 455175 >> 16 = 6.
    do_reset();
    for (int i = 0; i < TAPS; i++) wcoef(i, 255);
    for (int i = 0; i < 7; i++) begin
      send(255, lat);
      if (i < 6) @(negedge Clk);
    end
    check("sat.lat", lat, LAT);
    check("sat.fir", FIRout, 255);
    check("sat.root", ROOTout, 15);
    check("shift16.valid", Out_valid16, 1);
    check("shift16.fir", FIRout16, 6);
    check("shift16.root", ROOTout16, 2);
    @(negedge Clk);

    // Backpressure: result must hold for 20 cycles, extra input ignored.
    do_reset();
    wcoef(0, 1);
    Out_ready = 1'b0;
    send(81, lat);
    check("bp.lat", lat, LAT);
    In_valid = 1'b1;
    Data_i = 8'd200;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("bp.valid%0d", i), Out_valid, 1);
      check($sformatf("bp.fir%0d", i), FIRout, 81);
      check($sformatf("bp.root%0d", i), ROOTout, 9);
      check($sformatf("bp.in_ready%0d", i), In_ready, 0);
      @(negedge Clk);
    end
    In_valid = 1'b0;
    Out_ready = 1'b1;
    @(negedge Clk);
    check("bp.valid_clr", Out_valid, 0);
    check("bp.in_ready_set", In_ready, 1);
    // 200 was never accepted: the next sample is alone in x[0].
    send_check("bp.after", 49, 49, 7);

    // Coefficient write during MAC is ignored.
    In_valid = 1'b1;
    Data_i = 8'd50;
    @(negedge Clk);
    In_valid = 1'b0;
    Coef_we = 1'b1;
    Coef_addr = 3'd0;
    Coef_data = 8'd3;
    @(negedge Clk);
    @(negedge Clk);
    Coef_we = 1'b0;
    lat = 2;
    while (!Out_valid && lat < 60) begin
      @(negedge Clk);
      lat++;
    end
    check("macwe.fir", FIRout, 50);
    @(negedge Clk);
    send_check("macwe.next", 20, 20, 4);

    // Write and accept in the same IDLE cycle: new coefficient applies.
    Coef_we = 1'b1;
    Coef_addr = 3'd0;
    Coef_data = 8'd2;
    send_check("samecyc", 10, 20, 4);
    Coef_we = 1'b0;

    // Reset during MAC clears the delay line.
    do_reset();
    wcoef(0, 1);
    wcoef(1, 1);
    send_check("rmid.prime", 100, 100, 10);
    In_valid = 1'b1;
    Data_i = 8'd50;
    @(negedge Clk);
    In_valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("rmid.in_ready", In_ready, 1);
    check("rmid.out_valid", Out_valid, 0);
    wcoef(0, 1);
    wcoef(1, 1);
    send_check("rmid.after", 16, 16, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
